// File: rtl/mac_seq_engine.sv
// Time-multiplexed multiply-accumulate engine. Streams packed operand words from
// a combinational ROM, forms one lane product per cycle on a shared multiplier,
// and reduces the lane accumulators into an alternating-sign sum.
module mac_seq_engine #(
  parameter int unsigned EW    = 4,
  parameter int unsigned LANES = 4,
  parameter int unsigned ROT   = 2,
  parameter int unsigned AW    = 8,
  parameter int unsigned ACCW  = 16,
  localparam int unsigned WW   = 2 * LANES * EW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [AW-1:0]   base_addr_i,
  input  logic [AW-1:0]   num_words_i,
  input  logic            signed_mode_i,
  output logic [AW-1:0]   rom_addr_o,
  input  logic [WW-1:0]   rom_data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [ACCW-1:0] result_o
);

  localparam int unsigned LCW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StMul, StAcc, StFinal, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   rem_q;
  logic            sgn_q;
  logic [WW-1:0]   word_q;
  logic [LCW-1:0]  lane_q;
  logic [ACCW-1:0] prod_q [LANES];
  logic [ACCW-1:0] sum_q  [LANES];
  logic [ACCW-1:0] result_q;

  logic                lane_last;
  int unsigned         b_idx;
  logic [EW-1:0]       op_a, op_b;
  logic [2*EW-1:0]     op_a_x, op_b_x, prod_full;
  logic [ACCW-1:0]     prod_ext;
  logic [ACCW-1:0]     final_sum;

  assign lane_last  = (lane_q == LCW'(LANES - 1));
  assign rom_addr_o = ptr_q;
  assign result_o   = result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = (num_words_i != '0) ? StFetch : StFinal;
      end
      StFetch: begin
        busy_o  = 1'b1;
        state_d = StMul;
      end
      StMul: begin
        busy_o = 1'b1;
        if (lane_last) state_d = StAcc;
      end
      StAcc: begin
        busy_o  = 1'b1;
        state_d = (rem_q != '0) ? StFetch : StFinal;
      end
      StFinal: begin
        busy_o  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shared multiplier: lane j pairs element j with the rotated upper-half element.
  always_comb begin
    b_idx     = LANES + ((32'(lane_q) + ROT) % LANES);
    op_a      = EW'(word_q >> (32'(lane_q) * EW));
    op_b      = EW'(word_q >> (b_idx * EW));
    op_a_x    = sgn_q ? {{EW{op_a[EW-1]}}, op_a} : {{EW{1'b0}}, op_a};
    op_b_x    = sgn_q ? {{EW{op_b[EW-1]}}, op_b} : {{EW{1'b0}}, op_b};
    prod_full = op_a_x * op_b_x;
    prod_ext  = sgn_q ? ACCW'($signed(prod_full)) : ACCW'(prod_full);
  end

  // Alternating-sign reduction of the lane accumulators: even lanes add, odd subtract.
  always_comb begin
    final_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (k % 2 == 0) final_sum = final_sum + sum_q[k];
      else            final_sum = final_sum - sum_q[k];
    end
  end

  // Datapath registers sequenced by the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      rem_q    <= '0;
      sgn_q    <= 1'b0;
      word_q   <= '0;
      lane_q   <= '0;
      result_q <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        prod_q[k] <= '0;
        sum_q[k]  <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            ptr_q  <= base_addr_i;
            rem_q  <= num_words_i;
            sgn_q  <= signed_mode_i;
            lane_q <= '0;
            for (int unsigned k = 0; k < LANES; k++) sum_q[k] <= '0;
          end
        end
        StFetch: begin
          word_q <= rom_data_i;
          ptr_q  <= ptr_q + AW'(1);
          rem_q  <= rem_q - AW'(1);
          lane_q <= '0;
        end
        StMul: begin
          prod_q[lane_q] <= prod_ext;
          lane_q         <= lane_q + LCW'(1);
        end
        StAcc: begin
          for (int unsigned k = 0; k < LANES; k++) sum_q[k] <= sum_q[k] + prod_q[k];
        end
        StFinal: result_q <= final_sum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_engine.sv
// Bench for mac_seq_engine: default instance driven from a vector table and
// hand sequences, plus an 8-bit accumulator instance for modulo wrap.
module tb_mac_seq_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_mode;
  logic [7:0]  base_addr, num_words, rom_addr;
  logic [31:0] rom_data;
  logic        busy, done;
  logic [15:0] result;

  logic        start8, signed_mode8;
  logic [7:0]  base_addr8, num_words8, rom_addr8;
  logic [31:0] rom_data8;
  logic        busy8, done8;
  logic [7:0]  result8;

  logic [31:0] mem [256];
  logic [15:0] sb_q [$];
  logic [7:0]  addr_log [4];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        sgn;
    logic [7:0]  base;
    logic [7:0]  num;
    logic [31:0] word;
    logic [15:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  assign rom_data  = mem[rom_addr];
  assign rom_data8 = mem[rom_addr8];

  mac_seq_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .num_words_i  (num_words),
    .signed_mode_i(signed_mode),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .busy_o       (busy),
    .done_o       (done),
    .result_o     (result)
  );

  mac_seq_engine #(.ACCW(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start8),
    .base_addr_i  (base_addr8),
    .num_words_i  (num_words8),
    .signed_mode_i(signed_mode8),
    .rom_addr_o   (rom_addr8),
    .rom_data_i   (rom_data8),
    .busy_o       (busy8),
    .done_o       (done8),
    .result_o     (result8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [7:0] base, input logic [7:0] num, input logic [31:0] word);
    logic [7:0] a;
    for (int i = 0; i < int'(num); i++) begin
      a = base + 8'(i);
      mem[a] = word;
    end
  endtask

  // Issue one job; poke_c > 0 re-pulses start at that cycle count (must be ignored).
  task automatic run_job(input string name, input logic sgn, input logic [7:0] base,
                         input logic [7:0] num, input logic [15:0] exp_res,
                         input int exp_lat, input int poke_c);
    int         c;
    int         extra;
    bit         busy_ok;
    logic [15:0] exp_pop;
    @(negedge clk);
    start = 1'b1; signed_mode = sgn; base_addr = base; num_words = num;
    sb_q.push_back(exp_res);
    c = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      c++;
      start       = (c == poke_c);
      base_addr   = 8'($urandom);
      num_words   = 8'($urandom);
      signed_mode = 1'($urandom);
      for (int i = 0; i < 4; i++) if (c == 1 + i * 6) addr_log[i] = rom_addr;
      if (!done && busy !== 1'b1) busy_ok = 1'b0;
    end while (!done && c < 400);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_window"}, 32'(busy_ok), 32'd1);
    exp_pop = sb_q.pop_front();
    if (done) begin
      check({name, "_latency"}, c, exp_lat);
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      check({name, "_result"}, 32'(result), 32'(exp_pop));
    end
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    if (poke_c > 0) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check({name, "_poke_ignored"}, extra, 0);
      check({name, "_result_held"}, 32'(result), 32'(exp_res));
    end
  endtask

  initial begin
    int c;
    int extra;

    vecs[0] = '{"u_one",      1'b0, 8'h00, 8'd1, 32'h12345678, 16'h0012, 8};
    vecs[1] = '{"u_four",     1'b0, 8'h00, 8'd4, 32'h12345678, 16'h0048, 26};
    vecs[2] = '{"s_neg_sq",   1'b1, 8'h00, 8'd1, 32'h0F00000F, 16'h0001, 8};
    vecs[3] = '{"u_neg_sq",   1'b0, 8'h00, 8'd1, 32'h0F00000F, 16'h00E1, 8};
    vecs[4] = '{"zero_words", 1'b0, 8'h40, 8'd0, 32'h0,        16'h0000, 2};
    vecs[5] = '{"u_odd_lane", 1'b0, 8'h10, 8'd1, 32'h700000F0, 16'hFF97, 8};
    vecs[6] = '{"s_odd_lane", 1'b1, 8'h10, 8'd1, 32'h700000F0, 16'h0007, 8};
    vecs[7] = '{"s_three",    1'b1, 8'h30, 8'd3, 32'h700000F0, 16'h0015, 20};
    vecs[8] = '{"u_two",      1'b0, 8'h50, 8'd2, 32'h700000F0, 16'hFF2E, 14};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1;
    start = 1'b0; signed_mode = 1'b0; base_addr = 8'h0; num_words = 8'h0;
    start8 = 1'b0; signed_mode8 = 1'b0; base_addr8 = 8'h0; num_words8 = 8'h0;
    repeat (3) @(negedge clk);

    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_result",   32'(result),   32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_result8",  32'(result8),  32'd0);
    rst = 1'b0;

    // Table-driven jobs.
    for (int i = 0; i < 9; i++) begin
      fill(vecs[i].base, vecs[i].num, vecs[i].word);
      run_job(vecs[i].name, vecs[i].sgn, vecs[i].base, vecs[i].num,
              vecs[i].exp_res, vecs[i].exp_lat, 0);
    end

    // Address pointer wraps FE -> FF -> 00.
    fill(8'hFE, 8'd3, 32'h12345678);
    run_job("wrap", 1'b0, 8'hFE, 8'd3, 16'h0036, 20, 0);
    check("wrap_addr0", 32'(addr_log[0]), 32'h0FE);
    check("wrap_addr1", 32'(addr_log[1]), 32'h0FF);
    check("wrap_addr2", 32'(addr_log[2]), 32'h000);

    // start while busy, and start during DONE, must both be ignored.
    mem[0] = 32'h12345678;
    run_job("poke_busy", 1'b0, 8'h00, 8'd1, 16'h0012, 8, 3);
    mem[0] = 32'h0F00000F;
    run_job("poke_done", 1'b1, 8'h00, 8'd1, 16'h0001, 8, 8);

    // Reset in the middle of MUL aborts with no done.
    fill(8'h00, 8'd2, 32'h12345678);
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; base_addr = 8'h00; num_words = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_done",   32'(done),   32'd0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("abort_quiet", extra, 0);
    run_job("after_abort", 1'b0, 8'h00, 8'd2, 16'h0024, 14, 0);

    // 8-bit accumulator wraps modulo 256: 2 * 225 = 450 -> 0xC2.
    mem[8'h20] = 32'h0F00000F;
    mem[8'h21] = 32'h0F00000F;
    @(negedge clk);
    start8 = 1'b1; signed_mode8 = 1'b0; base_addr8 = 8'h20; num_words8 = 8'd2;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      start8 = 1'b0;
    end while (!done8 && c < 400);
    check("acc8_done",    32'(done8),   32'd1);
    check("acc8_latency", c,            14);
    check("acc8_result",  32'(result8), 32'h0C2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_seq_engine.md
Name: mac_seq_engine

Overview:
Parametrised, time-multiplexed multiply-accumulate engine that streams packed operand words from an external combinational ROM and produces one alternating-sign cross-product sum.
- Generalises the fixed 4-lane nibble MAC in element width, lane count, word count, base address, pairing rotation and signed mode.
- Adds a start/busy/done handshake so a controller can issue repeated jobs.

Parameters:
EW, 4, element width in bits
LANES, 4, products per word; word width WW = 2*LANES*EW
ROT, 2, partner rotation, range 0..LANES-1
AW, 8, ROM address width
ACCW, 16, lane accumulator and result width, ACCW >= 2*EW

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  job request, sampled only in IDLE
base_addr  input  AW  first word address, latched on start
num_words  input  AW  words to process, latched on start
signed_mode  input  1  1 = two's-complement elements, latched on start
rom_addr  output  AW  word address; ROM responds combinationally
rom_data  input  WW  word at rom_addr, same cycle
busy  output  1  high from FETCH/FINAL through FINAL
done  output  1  one-cycle pulse when result updates
result  output  ACCW  last job result, held until next done

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, rom_addr=0, all lane accumulators and product registers 0. Reset mid-job aborts the job with no done pulse.
- Elements: e[i] = word[i*EW +: EW], i = 0..2*LANES-1. Lane k (0..LANES-1) computes e[k] * e[LANES + ((k+ROT) mod LANES)].
- Products:
  - Each product is 2*EW bits.
  - signed_mode=0: operands and product are unsigned and zero-extended to ACCW.
  - signed_mode=1: operands and product are signed and sign-extended to ACCW.
- Arithmetic: lane accumulators S[k] add modulo 2^ACCW. result = sum over k of (+S[k] for even k, -S[k] for odd k), modulo 2^ACCW. No saturation.
- Hardware: one shared multiplier, one lane product per cycle, lane counter 0..LANES-1.
- FSM:
  - IDLE: on start, latch inputs, clear S[*], load address pointer from base_addr. Next state is FETCH if num_words != 0, else FINAL.
  - FETCH (1 cycle): rom_addr = pointer; latch rom_data into word register; pointer +1, wrapping modulo 2^AW; decrement remaining count. Next MUL.
  - MUL (LANES cycles): cycle j writes product of lane j into P[j]. Next ACC.
  - ACC (1 cycle): S[k] += P[k] for all k. Next FETCH if words remain, else FINAL.
  - FINAL (1 cycle): compute signed sum, load result. Next DONE.
  - DONE (1 cycle): done=1, busy=0. Next IDLE.
- Latency: start sampled in cycle N gives done in cycle N + 2 + num_words*(LANES+2).
  - Defaults, num_words=4: done at N+26.
  - num_words=0: done at N+2 with result 0.
- start outside IDLE (including DONE) is ignored. Inputs may change freely after start is accepted.
- rom_addr holds the pointer value in all states.
- Address wrap past 2^AW-1 is legal and wraps to 0.

Test Plan:
- Defaults, unsigned, one word 0x12345678 at base 0 -> products 16, 7, 24, 15; result 18 (0x0012); done 8 cycles after start.
- Same word at addresses 0..3, num_words=4 -> result 72 (0x0048); done exactly at N+26; busy high N+1..N+25.
- Word 0x0F00000F, num_words=1: signed_mode=1 -> result 1; signed_mode=0 -> result 225.
- ACCW=8, unsigned, two words 0x0F00000F -> 450 mod 256 = 194 (0xC2). base_addr=0xFE, num_words=3 -> rom_addr sequence FE, FF, 00.
- num_words=0 -> done at N+2, result 0. start pulsed while busy -> ignored, first job's result unaffected.
- rst asserted mid-MUL -> next cycle busy=0, result=0, no done. A fresh job afterwards gives the correct result.
